// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle for the SDRAM port arbiter: fetcher read side, renderer write side
// and the single controller port. The arbiter uses the slave view.
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 128
);
   logic              new_frame;
   logic              sdram_wait;
   logic              vid_rd;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_busy;
   logic              vid_ac;
   logic [DATA_W-1:0] vid_data;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ac;
   logic              sdram_rd;
   logic              sdram_wr;
   logic [ADDR_W-1:0] sdram_addr;
   logic [DATA_W-1:0] sdram_wdata;
   logic [DATA_W-1:0] sdram_rdata;
   logic              sdram_ac;
   logic              vid_late;

   modport slave (
      input  new_frame, sdram_wait, vid_rd, vid_addr, vid_busy,
             wr_req, wr_addr, wr_data, sdram_rdata, sdram_ac,
      output vid_ac, vid_data, wr_ac, sdram_rd, sdram_wr,
             sdram_addr, sdram_wdata, vid_late
   );

   modport master (
      output new_frame, sdram_wait, vid_rd, vid_addr, vid_busy,
             wr_req, wr_addr, wr_data, sdram_rdata, sdram_ac,
      input  vid_ac, vid_data, wr_ac, sdram_rd, sdram_wr,
             sdram_addr, sdram_wdata, vid_late
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the SDRAM controller port between the scanline fetcher (reads,
// strict priority) and the frame renderer (writes), and flags late read grants.
module sdram_port_arbiter #(
   parameter int ADDR_W   = 22,
   parameter int DATA_W   = 128,
   parameter int LATE_MAX = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   sdram_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      VID  = 2'd1,
      WR   = 2'd2
   } state_t;

   localparam logic [7:0] LATE_LIM = 8'(LATE_MAX);

   state_t            state_reg,   state_next;
   logic [ADDR_W-1:0] addr_reg,    addr_next;
   logic [DATA_W-1:0] wdata_reg,   wdata_next;
   logic [7:0]        lat_cnt_reg, lat_cnt_next;
   logic              late_reg,    late_next;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         lat_cnt_reg <= '0;
         late_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         lat_cnt_reg <= lat_cnt_next;
         late_reg    <= late_next;
      end
   end

   // Arbitration only happens from IDLE; an ack always lands us back in IDLE
   // for one cycle so requesters can update their level requests.
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      unique case (state_reg)
         IDLE: begin
            if (!bus.sdram_wait) begin
               if (bus.vid_rd) begin
                  state_next = VID;
                  addr_next  = bus.vid_addr;
               end else if (bus.wr_req && !bus.vid_busy) begin
                  state_next = WR;
                  addr_next  = bus.wr_addr;
                  wdata_next = bus.wr_data;
               end
            end
         end
         VID, WR: begin
            if (bus.sdram_ac) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Counts cycles a read request has waited without being in service.
   always_comb begin
      lat_cnt_next = lat_cnt_reg;
      late_next    = late_reg;
      if (!bus.vid_rd || state_reg == VID) begin
         lat_cnt_next = '0;
      end else if (lat_cnt_reg != 8'hFF) begin
         lat_cnt_next = lat_cnt_reg + 8'd1;
      end
      if (lat_cnt_reg >= LATE_LIM) begin
         late_next = 1'b1;
      end else if (bus.new_frame) begin
         late_next = 1'b0;
      end
   end

   assign bus.sdram_rd    = (state_reg == VID);
   assign bus.sdram_wr    = (state_reg == WR);
   assign bus.sdram_addr  = addr_reg;
   assign bus.sdram_wdata = wdata_reg;
   assign bus.vid_ac      = bus.sdram_ac && (state_reg == VID);
   assign bus.wr_ac       = bus.sdram_ac && (state_reg == WR);
   assign bus.vid_data    = bus.sdram_rdata;
   assign bus.vid_late    = late_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scoreboard bench for sdram_port_arbiter: a transaction-level model
// predicts grants and flags, a negedge monitor compares against the DUT.
module tb_sdram_port_arbiter;
   localparam int ADDR_W   = 22;
   localparam int DATA_W   = 128;
   localparam int LATE_MAX = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATE_MAX(LATE_MAX)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the port, pending expected grants, wait run length.
   typedef struct {
      int                kind;   // 1 = read, 2 = write
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } txn_t;

   txn_t exp_q[$];
   txn_t m_t;
   int   m_owner = 0;
   int   m_run   = 0;
   logic m_late  = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_owner = 0;
         m_run   = 0;
         m_late  = 1'b0;
         exp_q.delete();
      end else begin
         if (m_run >= LATE_MAX) m_late = 1'b1;
         else if (bus.new_frame) m_late = 1'b0;
         m_run = (!bus.vid_rd || m_owner == 1) ? 0 : ((m_run < 255) ? m_run + 1 : 255);
         if (m_owner != 0) begin
            if (bus.sdram_ac) m_owner = 0;
         end else if (!bus.sdram_wait) begin
            if (bus.vid_rd) begin
               m_owner = 1;
               m_t.kind = 1; m_t.addr = bus.vid_addr; m_t.data = '0;
               exp_q.push_back(m_t);
            end else if (bus.wr_req && !bus.vid_busy) begin
               m_owner = 2;
               m_t.kind = 2; m_t.addr = bus.wr_addr; m_t.data = bus.wr_data;
               exp_q.push_back(m_t);
            end
         end
      end
   end

   // Monitor
   logic              prev_strobe = 1'b0;
   logic [ADDR_W-1:0] cur_addr = '0;
   logic [ADDR_W-1:0] last_rd_addr = '0, last_wr_addr = '0;
   logic [DATA_W-1:0] last_wr_data = '0;
   int cyc = 0, rd_cycles = 0, wr_cycles = 0, vid_acks = 0, wr_acks = 0;
   int last_vid_ack_cyc = 0, last_wr_rise_cyc = 0;
   txn_t pop_t;

   always @(negedge clock) begin
      logic strobe;
      cyc++;
      strobe = bus.sdram_rd || bus.sdram_wr;
      check("sdram_rd", 128'(bus.sdram_rd), 128'(m_owner == 1));
      check("sdram_wr", 128'(bus.sdram_wr), 128'(m_owner == 2));
      check("vid_ac", 128'(bus.vid_ac), 128'(bus.sdram_ac && m_owner == 1));
      check("wr_ac", 128'(bus.wr_ac), 128'(bus.sdram_ac && m_owner == 2));
      check("vid_data", bus.vid_data, bus.sdram_rdata);
      check("vid_late", 128'(bus.vid_late), 128'(m_late));
      if (strobe && !prev_strobe) begin
         check("grant_queue_depth", 128'(exp_q.size()), 128'(1));
         if (exp_q.size() != 0) begin
            pop_t = exp_q.pop_front();
            check("grant_kind", 128'(bus.sdram_wr ? 2 : 1), 128'(pop_t.kind));
            check("grant_addr", 128'(bus.sdram_addr), 128'(pop_t.addr));
            if (pop_t.kind == 2) check("grant_wdata", bus.sdram_wdata, pop_t.data);
         end
         cur_addr = bus.sdram_addr;
         if (bus.sdram_wr) begin
            last_wr_rise_cyc = cyc;
            last_wr_addr     = bus.sdram_addr;
            last_wr_data     = bus.sdram_wdata;
         end else begin
            last_rd_addr = bus.sdram_addr;
         end
      end else if (strobe) begin
         check("addr_hold", 128'(bus.sdram_addr), 128'(cur_addr));
      end
      check("grant_queue_empty", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
      prev_strobe = strobe;
      if (bus.sdram_rd) rd_cycles++;
      if (bus.sdram_wr) wr_cycles++;
      if (bus.vid_ac) begin vid_acks++; last_vid_ack_cyc = cyc; end
      if (bus.wr_ac) wr_acks++;
   end

   // Environment: requesters and controller, driven just after the rising edge.
   int p_vid = 0, b2b = 0, p_wr = 0, p_wait = 0, busy_mode = 2, p_nf = 0, fix_dly = -1;
   bit stray_en = 1'b0, hold_ack = 1'b0, ctl_pending = 1'b0;
   int ctl_dly = 0;

   task automatic set_knobs(input int pv, input int bb, input int pw, input int pwt,
                            input int bm, input int nf, input int fd, input bit st);
      p_vid = pv; b2b = bb; p_wr = pw; p_wait = pwt;
      busy_mode = bm; p_nf = nf; fix_dly = fd; stray_en = st;
   endtask

   task automatic step();
      logic s_vid_ac, s_wr_ac, s_strobe, s_ac;
      @(negedge clock);
      s_vid_ac = bus.vid_ac;
      s_wr_ac  = bus.wr_ac;
      s_strobe = bus.sdram_rd || bus.sdram_wr;
      s_ac     = bus.sdram_ac;
      @(posedge clock);
      #1;
      if (s_vid_ac) begin
         if (int'($urandom_range(0, 99)) < b2b) bus.vid_addr = ADDR_W'($urandom());
         else bus.vid_rd = 1'b0;
      end else if (!bus.vid_rd && int'($urandom_range(0, 99)) < p_vid) begin
         bus.vid_rd   = 1'b1;
         bus.vid_addr = ADDR_W'($urandom());
      end
      if (s_wr_ac || (!bus.wr_req && int'($urandom_range(0, 99)) < p_wr)) begin
         bus.wr_req  = int'($urandom_range(0, 99)) < p_wr;
         bus.wr_addr = ADDR_W'($urandom());
         bus.wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      case (busy_mode)
         0:       if ($urandom_range(0, 19) == 0) bus.vid_busy = ~bus.vid_busy;
         1:       bus.vid_busy = 1'b1;
         default: bus.vid_busy = 1'b0;
      endcase
      bus.sdram_wait  = int'($urandom_range(0, 99)) < p_wait;
      bus.new_frame   = int'($urandom_range(0, 99)) < p_nf;
      bus.sdram_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (s_ac) begin
         bus.sdram_ac = 1'b0;
         ctl_pending  = 1'b0;
      end else if (s_strobe && !hold_ack) begin
         if (!ctl_pending) begin
            ctl_pending = 1'b1;
            ctl_dly     = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
         end
         if (ctl_dly == 0) bus.sdram_ac = 1'b1;
         else begin ctl_dly--; bus.sdram_ac = 1'b0; end
      end else if (!s_strobe && !ctl_pending && stray_en && $urandom_range(0, 15) == 0) begin
         bus.sdram_ac = 1'b1;   // stray ack: ignored if the arbiter is idle
      end else begin
         bus.sdram_ac = 1'b0;
      end
   endtask

   initial begin
      int r0, a0, w0;
      bit seen;
      bus.new_frame = 0; bus.sdram_wait = 0; bus.vid_rd = 0; bus.vid_addr = '0;
      bus.vid_busy = 0; bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.sdram_rdata = '0; bus.sdram_ac = 0;
      repeat (3) step();
      check("rst_sdram_addr", 128'(bus.sdram_addr), 128'(0));
      check("rst_sdram_wdata", bus.sdram_wdata, 128'(0));
      reset = 1'b0;

      // Single read, ack two cycles after the strobe rises.
      set_knobs(0, 0, 0, 0, 2, 0, 1, 1'b0);
      step();
      bus.vid_rd = 1'b1; bus.vid_addr = 22'h100028;
      r0 = rd_cycles; a0 = vid_acks;
      repeat (8) step();
      check("t1_rd_cycles", 128'(rd_cycles - r0), 128'(3));
      check("t1_vid_acks", 128'(vid_acks - a0), 128'(1));
      check("t1_addr", 128'(last_rd_addr), 128'(22'h100028));

      // Read and write requested together: read first, write two cycles after vid_ac.
      step();
      bus.vid_rd = 1'b1; bus.vid_addr = 22'h0001a0;
      bus.wr_req = 1'b1; bus.wr_addr = 22'h2abcd0; bus.wr_data = {4{32'hc0ffee11}};
      repeat (14) step();
      check("t2_wr_gap", 128'(last_wr_rise_cyc - last_vid_ack_cyc), 128'(2));
      check("t2_wr_addr", 128'(last_wr_addr), 128'(22'h2abcd0));
      check("t2_wr_data", last_wr_data, {4{32'hc0ffee11}});

      // Line fetch with vid_busy high: writes held off, then one gets through.
      set_knobs(100, 100, 100, 0, 1, 0, 1, 1'b1);
      repeat (8) step();
      r0 = wr_cycles; a0 = vid_acks;
      repeat (200) step();
      check("t3_no_wr_while_busy", 128'(wr_cycles - r0), 128'(0));
      check("t3_line_reads", 128'((vid_acks - a0) >= 40), 128'(1));
      w0 = wr_acks;
      set_knobs(0, 0, 100, 0, 2, 0, 1, 1'b1);
      repeat (20) step();
      check("t3_wr_after_busy", 128'(wr_acks > w0), 128'(1));

      // Late flag under sdram_wait.
      set_knobs(0, 0, 0, 0, 2, 0, -1, 1'b0);
      repeat (12) step();
      bus.new_frame = 1'b1;
      step();
      set_knobs(100, 0, 0, 100, 2, 0, -1, 1'b0);
      step();
      repeat (16) step();
      check("t4_late_before", 128'(bus.vid_late), 128'(0));
      step();
      check("t4_late_set", 128'(bus.vid_late), 128'(1));
      repeat (4) step();
      bus.new_frame = 1'b1;
      step();
      check("t4_late_set_wins", 128'(bus.vid_late), 128'(1));
      set_knobs(0, 0, 0, 0, 2, 0, -1, 1'b0);
      repeat (10) step();
      bus.new_frame = 1'b1;
      step();
      step();
      check("t4_late_clear", 128'(bus.vid_late), 128'(0));

      // Reset during a write, before the controller acks.
      set_knobs(0, 0, 100, 0, 2, 0, -1, 1'b0);
      hold_ack = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         seen = bus.sdram_wr;
      end
      check("t5_wr_seen", 128'(seen), 128'(1));
      step();
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_sdram_wr", 128'(bus.sdram_wr), 128'(0));
      check("t5_rst_wr_ac", 128'(bus.wr_ac), 128'(0));
      repeat (2) step();
      reset = 1'b0; hold_ack = 1'b0; ctl_pending = 1'b0;
      w0 = wr_acks;
      repeat (15) step();
      check("t5_regrant", 128'(wr_acks > w0), 128'(1));

      // Mixed random traffic.
      set_knobs(30, 50, 30, 10, 0, 2, -1, 1'b1);
      repeat (3000) step();
      set_knobs(60, 80, 60, 25, 0, 5, -1, 1'b1);
      repeat (1500) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-requester arbiter for the single SDRAM controller port, shared between the scanline fetcher (reads 128-bit words into the line buffer) and the frame renderer (writes 128-bit words into the back framebuffer). Video reads have strict priority. Writes are held off for the whole time the fetcher reports busy, so a 40-word line fetch runs back-to-back. The block also monitors read-grant latency and raises a sticky late flag for the current frame.

## Interface
Parameters:
- ADDR_W, 22, SDRAM word address width
- DATA_W, 128, SDRAM data width
- LATE_MAX, 16, maximum wait cycles between vid_rd rising and its grant before vid_late sets

Ports:
- clock  in  1  system clock; every register is rising-edge
- reset  in  1  asynchronous, active-high reset
- new_frame  in  1  one-cycle pulse, synchronous to clock; clears vid_late
- sdram_wait  in  1  controller not ready (init/refresh); no new grant while high
- vid_rd  in  1  fetcher read request; level, held until vid_ac
- vid_addr  in  ADDR_W  fetcher read address
- vid_busy  in  1  fetcher is inside a line fetch; blocks write grants
- vid_ac  out  1  read done; vid_data valid this cycle
- vid_data  out  DATA_W  read data (passthrough of sdram_rdata)
- wr_req  in  1  renderer write request; level, held until wr_ac
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ac  out  1  write accepted by controller
- sdram_rd  out  1  read strobe to controller
- sdram_wr  out  1  write strobe to controller
- sdram_addr  out  ADDR_W  address to controller
- sdram_wdata  out  DATA_W  write data to controller
- sdram_rdata  in  DATA_W  read data from controller
- sdram_ac  in  1  controller acknowledge; one-cycle pulse per access
- vid_late  out  1  sticky: a read grant exceeded LATE_MAX this frame

## Operation
States: IDLE, VID, WR.

IDLE:
- If sdram_wait is high, stay in IDLE.
- Else if vid_rd is high, go to VID and latch vid_addr into the address register.
- Else if wr_req is high and vid_busy is low, go to WR and latch wr_addr and wr_data.
- Else stay in IDLE.

VID:
- sdram_rd=1. sdram_addr = latched address.
- On sdram_ac, go to IDLE.

WR:
- sdram_wr=1. sdram_addr and sdram_wdata = latched values.
- On sdram_ac, go to IDLE.

Rules that apply in every state:
- A transaction in progress is never preempted. sdram_wait is ignored once in VID or WR.
- Strobe and address outputs are decoded from registered state and latched registers only, so they are glitch-free.
- vid_ac = sdram_ac & (state==VID). wr_ac = sdram_ac & (state==WR). Both are combinational, zero-latency.
- vid_data = sdram_rdata at all times.
- Every access returns to IDLE for at least one cycle, so a requester sees its ack and updates its request before the next arbitration.
- sdram_ac while in IDLE is ignored; no ack is produced.

Latency monitor:
- 8-bit counter. It clears when vid_rd is low or when state is VID. Otherwise it increments while vid_rd is high, saturating at 255.
- When the counter reaches LATE_MAX, vid_late sets.
- new_frame clears vid_late. If new_frame and the set condition occur in the same cycle, the set wins.

## Timing
- Reset values: state=IDLE; sdram_rd=sdram_wr=0; sdram_addr=0; sdram_wdata=0; vid_ac=wr_ac=0; vid_late=0; latency counter=0.
- Reset asserted mid-transaction drops the strobes immediately (asynchronous). The controller must abandon the access.
- Request-to-strobe: request seen high in IDLE at edge N gives the strobe high from edge N+1.
- Strobe stays high until the cycle of sdram_ac inclusive. It is low the next cycle.
- Back-to-back video reads: the fetcher re-requests the cycle after vid_ac. One arbiter-level cycle separates accesses: ack, IDLE, strobe.
- vid_rd and wr_req both high in IDLE: VID is granted. wr_req stays pending without being acked.
- wr_req with vid_busy high: no grant. The write is granted in the first IDLE cycle with vid_busy=0, vid_rd=0 and sdram_wait=0.
- Requests are never lost. A pending level request is re-evaluated every IDLE cycle.

## Test plan
- Reset, then vid_rd=1 with vid_addr=22'h100028 and sdram_ac two cycles after the strobe -> sdram_rd high exactly 3 cycles, sdram_addr=22'h100028, vid_ac a single pulse, vid_data equals sdram_rdata.
- vid_rd and wr_req rise in the same cycle -> read served first. The write strobe starts 2 cycles after vid_ac, with wr_addr/wr_data latched.
- vid_busy=1 across a 40-read line, with wr_req held throughout -> zero sdram_wr cycles until vid_busy falls. Then one write with wr_ac=1.
- sdram_wait=1 for 20 cycles with vid_rd high -> no strobe. vid_late sets at wait count 16. new_frame clears it. A simultaneous set and new_frame leaves vid_late=1.
- Assert reset during WR before sdram_ac -> sdram_wr and wr_ac 0 immediately. State is IDLE on release. A held wr_req is re-granted afterwards.
